montgomery_mult_iter: RTL and testbench

//  Sequential, digit-serial Montgomery multiplier: P = A*B*2^-WIDTH mod N.

---
 rtl/montgomery_mult_iter_pkg.sv | 5 +
 rtl/montgomery_mult_iter_if.sv | 15 +
 rtl/montgomery_mult_iter_digit_step.sv | 22 ++
 rtl/montgomery_mult_iter.sv | 63 ++++++
 tb/tb_montgomery_mult_iter.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/montgomery_mult_iter_pkg.sv
// montgomery_mult_iter_pkg: shared default width and FSM state encoding
package montgomery_mult_iter_pkg;
  localparam int BITS = 32;
  typedef enum logic [1:0] {IDLE, ITER, FINAL, DONE} state_e;
endpackage

// File: rtl/montgomery_mult_iter_if.sv
// montgomery_mult_iter_if: operand/result valid-ready bus
// master drives in_valid, A, B, N, n0_inv, out_ready; slave drives in_ready, out_valid, P
interface montgomery_mult_iter_if #(parameter int WIDTH = 32, parameter int DIGIT = 1);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] N;
  logic [DIGIT-1:0] n0_inv;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] P;
  modport master(output in_valid, A, B, N, n0_inv, out_ready, input in_ready, out_valid, P);
  modport slave(input in_valid, A, B, N, n0_inv, out_ready, output in_ready, out_valid, P);
endinterface

// File: rtl/montgomery_mult_iter_digit_step.sv
// montgomery_mult_iter_digit_step: one Montgomery reduction step consuming DIGIT bits of A
// t: accumulator (< 2N), a_i: digit of A, b/n: operands, n0_inv: -N^-1 mod 2^DIGIT, t_nx: next accumulator
module montgomery_mult_iter_digit_step #(parameter int WIDTH = 32, parameter int DIGIT = 1) (
  input  logic [WIDTH:0]   t,
  input  logic [DIGIT-1:0] a_i,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  input  logic [DIGIT-1:0] n0_inv,
  output logic [WIDTH:0]   t_nx
);
  localparam int UW = WIDTH + DIGIT + 2;
  logic [UW-1:0] u;
  logic [UW-1:0] v;
  logic [DIGIT-1:0] q;
  always_comb begin
    u = UW'(t) + UW'(a_i) * UW'(b);
    q = u[DIGIT-1:0] * n0_inv;
    v = u + UW'(q) * UW'(n);
    // low DIGIT bits of v are zero, so the shift is an exact division
    t_nx = (WIDTH+1)'(v >> DIGIT);
  end
endmodule

// File: rtl/montgomery_mult_iter.sv
// montgomery_mult_iter: digit-serial Montgomery multiplier P = A*B*2^-WIDTH mod N
// clk, rst_n (async active-low); bus.slave carries in_valid/in_ready/A/B/N/n0_inv and out_valid/out_ready/P
module montgomery_mult_iter
  import montgomery_mult_iter_pkg::*;
#(parameter int WIDTH = BITS, parameter int DIGIT = 1) (
  input logic clk,
  input logic rst_n,
  montgomery_mult_iter_if.slave bus
);
  localparam int ITERS = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(ITERS + 1);
  if (DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_param
    $error("montgomery_mult_iter: DIGIT must divide WIDTH");
  end
  state_e state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r, n_r, p_r;
  logic [DIGIT-1:0] n0_r, a_i;
  logic [WIDTH:0] t_r, t_nx;
  logic accept, last;
  assign a_i = a_r[cnt*DIGIT +: DIGIT];
  assign last = cnt == CNT_W'(ITERS - 1);
  assign accept = state == IDLE && bus.in_valid;
  assign bus.P = p_r;
  montgomery_mult_iter_digit_step #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_step (
    .t(t_r), .a_i(a_i), .b(b_r), .n(n_r), .n0_inv(n0_r), .t_nx(t_nx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (bus.in_valid ? ITER : IDLE) :
              state == ITER  ? (last ? FINAL : ITER) :
              state == FINAL ? DONE :
                               (bus.out_ready ? IDLE : DONE);
    bus.in_ready = state == IDLE;
    bus.out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      t_r <= '0;
      a_r <= '0;
      b_r <= '0;
      n_r <= '0;
      n0_r <= '0;
      p_r <= '0;
    end else if (accept) begin
      cnt <= '0;
      t_r <= '0;
      a_r <= bus.A;
      b_r <= bus.B;
      n_r <= bus.N;
      n0_r <= bus.n0_inv;
    end else if (state == ITER) begin
      cnt <= cnt + CNT_W'(1);
      t_r <= t_nx;
    end else if (state == FINAL) begin
      // T < 2N, so a single conditional subtraction fully reduces it
      p_r <= t_r >= {1'b0, n_r} ? WIDTH'(t_r - {1'b0, n_r}) : t_r[WIDTH-1:0];
    end
endmodule

// File: tb/tb_montgomery_mult_iter.sv
// tb_montgomery_mult_iter: scoreboard bench over several WIDTH/DIGIT instances
module tb_montgomery_mult_iter;
  import montgomery_mult_iter_pkg::*;
  localparam int NC = 7;
  function automatic int cw(int g);
    return g < 2 ? 8 : 32;
  endfunction
  function automatic int cd(int g);
    return g == 0 ? 1 : g == 1 ? 4 : g == 2 ? 1 : g == 3 ? 2 : g == 4 ? 4 : g == 5 ? 8 : 32;
  endfunction
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] a_d, b_d, n_d, n0_d;
  logic [NC-1:0] iv, ordy, irdy, ov;
  logic [31:0] p_o [NC];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int W = cw(g);
    localparam int D = cd(g);
    montgomery_mult_iter_if #(.WIDTH(W), .DIGIT(D)) bus();
    assign bus.in_valid = iv[g];
    assign bus.out_ready = ordy[g];
    assign bus.A = a_d[W-1:0];
    assign bus.B = b_d[W-1:0];
    assign bus.N = n_d[W-1:0];
    assign bus.n0_inv = n0_d[D-1:0];
    assign irdy[g] = bus.in_ready;
    assign ov[g] = bus.out_valid;
    assign p_o[g] = 32'(bus.P);
    montgomery_mult_iter #(.WIDTH(W), .DIGIT(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  end
  // reference: reduce A*B mod N, then divide by 2 mod N w times
  function automatic logic [31:0] model(int w, logic [31:0] a, logic [31:0] b, logic [31:0] n);
    logic [63:0] x;
    x = ({32'b0, a} * {32'b0, b}) % {32'b0, n};
    for (int i = 0; i < w; i++) x = x[0] ? (x + {32'b0, n}) >> 1 : x >> 1;
    return x[31:0];
  endfunction
  // -N^-1 mod 2^32 by Newton iteration; callers truncate to DIGIT bits
  function automatic logic [31:0] n0_of(logic [31:0] n);
    logic [31:0] inv;
    inv = n;
    for (int i = 0; i < 5; i++) inv = inv * (32'd2 - n * inv);
    return -inv;
  endfunction
  task automatic run_op(int k, logic [31:0] a, logic [31:0] b, logic [31:0] n, logic [31:0] n0, bit bp);
    int cyc;
    logic [31:0] ex, pv;
    ordy[k] = !bp;
    @(negedge clk);
    a_d = a; b_d = b; n_d = n; n0_d = n0; iv[k] = 1'b1;
    exp_q.push_back(model(cw(k), a, b, n));
    checks++;
    if (irdy[k] !== 1'b1) begin errors++; $display("FAIL in_ready_idle k=%0d got %b exp 1", k, irdy[k]); end
    @(posedge clk);
    cyc = 1;
    forever begin
      @(negedge clk);
      iv[k] = 1'b0; a_d = $urandom; b_d = $urandom; n_d = $urandom; n0_d = $urandom;
      if (ov[k] === 1'b1 || cyc > 200) break;
      checks++;
      if (irdy[k] !== 1'b0) begin errors++; $display("FAIL in_ready_busy k=%0d cyc=%0d got %b exp 0", k, cyc, irdy[k]); end
      @(posedge clk);
      cyc++;
    end
    checks++;
    if (cyc != cw(k) / cd(k) + 2) begin errors++; $display("FAIL latency k=%0d got %0d exp %0d", k, cyc, cw(k) / cd(k) + 2); end
    ex = exp_q.pop_front();
    checks++;
    if (p_o[k] !== ex) begin errors++; $display("FAIL result k=%0d A=%0h B=%0h N=%0h got %0h exp %0h", k, a, b, n, p_o[k], ex); end
    if (bp) begin
      pv = p_o[k];
      iv[k] = 1'b1;
      repeat (20) begin
        @(negedge clk);
        checks++;
        if (ov[k] !== 1'b1 || p_o[k] !== pv || irdy[k] !== 1'b0)
          begin errors++; $display("FAIL hold k=%0d got ov=%b p=%0h rdy=%b exp ov=1 p=%0h rdy=0", k, ov[k], p_o[k], irdy[k], pv); end
      end
      iv[k] = 1'b0;
      ordy[k] = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (ov[k] !== 1'b0 || irdy[k] !== 1'b1) begin errors++; $display("FAIL release k=%0d got ov=%b rdy=%b exp ov=0 rdy=1", k, ov[k], irdy[k]); end
  endtask
  task automatic test_reset;
    iv = '0; ordy = '1; a_d = '0; b_d = '0; n_d = '0; n0_d = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NC; k++) begin
      checks++;
      if (irdy[k] !== 1'b1 || ov[k] !== 1'b0 || p_o[k] !== 32'd0)
        begin errors++; $display("FAIL reset k=%0d got rdy=%b ov=%b p=%0h exp rdy=1 ov=0 p=0", k, irdy[k], ov[k], p_o[k]); end
    end
    rst_n = 1'b1;
  endtask
  task automatic test_basic;
    run_op(0, 32'd5, 32'd7, 32'd13, 32'd1, 1'b0);
    run_op(1, 32'd1, 32'd1, 32'd13, 32'd11, 1'b0);
    run_op(1, 32'd0, 32'd12, 32'd13, 32'd11, 1'b0);
  endtask
  task automatic test_final_subtract;
    run_op(0, 32'd254, 32'd254, 32'd255, 32'd1, 1'b0);
  endtask
  task automatic test_full_digit;
    run_op(6, 32'd3797488404, 32'd3797488404, 32'd4292870399, 32'd3235971329, 1'b0);
  endtask
  task automatic test_backpressure;
    run_op(4, 32'h1234_5678, 32'h0abc_def1, 32'hf000_0001, n0_of(32'hf000_0001), 1'b1);
  endtask
  task automatic test_reset_mid;
    ordy[2] = 1'b1;
    @(negedge clk);
    a_d = 32'd5; b_d = 32'd7; n_d = 32'd13; n0_d = n0_of(32'd13); iv[2] = 1'b1;
    @(negedge clk);
    iv[2] = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (irdy[2] !== 1'b0) begin errors++; $display("FAIL busy_before_reset got %b exp 0", irdy[2]); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov[2] !== 1'b0 || irdy[2] !== 1'b1 || p_o[2] !== 32'd0)
      begin errors++; $display("FAIL async_reset got ov=%b rdy=%b p=%0h exp ov=0 rdy=1 p=0", ov[2], irdy[2], p_o[2]); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2, 32'd5, 32'd7, 32'd13, n0_of(32'd13), 1'b0);
  endtask
  task automatic test_random;
    logic [31:0] n, a, b;
    for (int k = 2; k < NC; k++)
      for (int i = 0; i < 150; i++) begin
        n = $urandom | 32'd1;
        if (i % 3 == 0) n[31] = 1'b1;
        a = $urandom % n;
        b = (i % 7 == 0) ? n - 32'd1 : $urandom % n;
        run_op(k, a, b, n, n0_of(n), 1'b0);
      end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_final_subtract();
    test_full_digit();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
